// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate mode, terminal-count pulse and sticky overflow.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int RST_VAL  = MAX_VAL,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  if (WIDTH < 2 || MAX_VAL > (1 << WIDTH) - 1 || RST_VAL > MAX_VAL || PRESCALE < 1) begin : g_param_check
    $error("updown_counter_param: illegal parameter combination");
  end

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  // Value after a step; at a bound it either wraps to the opposite bound or holds.
  function automatic logic [WIDTH-1:0] bound_step(input logic [WIDTH-1:0] c,
                                                  input logic up,
                                                  input logic at_bound,
                                                  input logic [WIDTH-1:0] stepped);
    if (!at_bound) return stepped;
    if (SATURATE)  return c;
    return up ? '0 : MAX_C;
  endfunction

  logic             tick;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             at_bound;
  logic [WIDTH-1:0] next_count;

`ifdef COUNTER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  always_ff @(posedge clk) begin
    if (!reset || load) begin
      ps_cnt <= '0;
    end else if (en) begin
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
    end
  end

  assign tick = en && (ps_cnt == PS_LAST);
`else
  assign tick = en;
`endif

  // One extra bit: carry past MAX_VAL marks the upper bound, borrow marks the lower one.
  always_comb begin
    inc_ext    = {1'b0, count} + (WIDTH + 1)'(1);
    dec_ext    = {1'b0, count} - (WIDTH + 1)'(1);
    at_bound   = up_dn ? (inc_ext > {1'b0, MAX_C}) : dec_ext[WIDTH];
    next_count = bound_step(count, up_dn, at_bound,
                            up_dn ? inc_ext[WIDTH-1:0] : dec_ext[WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= RST_C;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= clamp_load(load_val);
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (tick) begin
      count <= next_count;
      tc    <= at_bound;
      if (at_bound) ovf <= 1'b1;
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: default wrap counter, saturating counter and MAX_VAL=9 counter share one stimulus.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] count_w, count_s, count_m;
  logic       tc_w, tc_s, tc_m, ovf_w, ovf_s, ovf_m;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  updown_counter_param dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count_w), .tc(tc_w), .ovf(ovf_w));

  updown_counter_param #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count_s), .tc(tc_s), .ovf(ovf_s));

  updown_counter_param #(.MAX_VAL(9)) dut_m9 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count_m), .tc(tc_m), .ovf(ovf_m));

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v);
    reset = r; en = e; up_dn = u; load = l; load_val = v;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step_clk();
    total++;
    if (count_w !== 4'd15 || tc_w !== 1'b0 || ovf_w !== 1'b0) begin
      bad++;
      $display("FAIL reset_wrap: got count=%0d tc=%b ovf=%b want 15 0 0", count_w, tc_w, ovf_w);
    end
    total++;
    if (count_m !== 4'd9 || tc_m !== 1'b0) begin
      bad++;
      $display("FAIL reset_m9: got count=%0d tc=%b want 9 0", count_m, tc_m);
    end
  endtask

  task automatic test_down_wrap();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 14; i >= 0; i--) begin
      step_clk();
      total++;
      if (count_w !== 4'(i) || tc_w !== 1'b0 || ovf_w !== 1'b0) begin
        bad++;
        $display("FAIL down_step: got count=%0d tc=%b ovf=%b want %0d 0 0", count_w, tc_w, ovf_w, i);
      end
    end
    step_clk();
    total++;
    if (count_w !== 4'd15 || tc_w !== 1'b1 || ovf_w !== 1'b1) begin
      bad++;
      $display("FAIL down_wrap: got count=%0d tc=%b ovf=%b want 15 1 1", count_w, tc_w, ovf_w);
    end
    step_clk();
    total++;
    if (count_w !== 4'd14 || tc_w !== 1'b0 || ovf_w !== 1'b1) begin
      bad++;
      $display("FAIL down_after_wrap: got count=%0d tc=%b ovf=%b want 14 0 1", count_w, tc_w, ovf_w);
    end
  endtask

  task automatic test_up_wrap_hold();
    logic [3:0] exp_c [3] = '{4'd14, 4'd15, 4'd0};
    logic       exp_t [3] = '{1'b0, 1'b0, 1'b1};
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd13);
    step_clk();
    total++;
    if (count_w !== 4'd13 || ovf_w !== 1'b0) begin
      bad++;
      $display("FAIL load_clears_ovf: got count=%0d ovf=%b want 13 0", count_w, ovf_w);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step_clk();
      total++;
      if (count_w !== exp_c[i] || tc_w !== exp_t[i]) begin
        bad++;
        $display("FAIL up_step%0d: got count=%0d tc=%b want %0d %b", i, count_w, tc_w, exp_c[i], exp_t[i]);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step_clk();
      total++;
      if (count_w !== 4'd0 || tc_w !== 1'b0 || ovf_w !== 1'b1) begin
        bad++;
        $display("FAIL en_low_hold%0d: got count=%0d tc=%b ovf=%b want 0 0 1", i, count_w, tc_w, ovf_w);
      end
    end
  endtask

  task automatic test_saturate();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd14);
    step_clk();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    step_clk();
    total++;
    if (count_s !== 4'd15 || tc_s !== 1'b0 || ovf_s !== 1'b0) begin
      bad++;
      $display("FAIL sat_reach: got count=%0d tc=%b ovf=%b want 15 0 0", count_s, tc_s, ovf_s);
    end
    for (int i = 0; i < 2; i++) begin
      step_clk();
      total++;
      if (count_s !== 4'd15 || tc_s !== 1'b1 || ovf_s !== 1'b1) begin
        bad++;
        $display("FAIL sat_hold%0d: got count=%0d tc=%b ovf=%b want 15 1 1", i, count_s, tc_s, ovf_s);
      end
    end
    up_dn = 1'b0;
    step_clk();
    total++;
    if (count_s !== 4'd14 || tc_s !== 1'b0 || ovf_s !== 1'b1) begin
      bad++;
      $display("FAIL sat_turn_down: got count=%0d tc=%b ovf=%b want 14 0 1", count_s, tc_s, ovf_s);
    end
  endtask

  task automatic test_max_val();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd12);
    step_clk();
    total++;
    if (count_m !== 4'd9) begin
      bad++;
      $display("FAIL m9_load_clamp: got count=%0d want 9", count_m);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    step_clk();
    total++;
    if (count_m !== 4'd0 || tc_m !== 1'b1 || ovf_m !== 1'b1) begin
      bad++;
      $display("FAIL m9_up_wrap: got count=%0d tc=%b ovf=%b want 0 1 1", count_m, tc_m, ovf_m);
    end
    up_dn = 1'b0;
    step_clk();
    total++;
    if (count_m !== 4'd9 || tc_m !== 1'b1) begin
      bad++;
      $display("FAIL m9_down_wrap: got count=%0d tc=%b want 9 1", count_m, tc_m);
    end
    step_clk();
    total++;
    if (count_m !== 4'd8 || tc_m !== 1'b0) begin
      bad++;
      $display("FAIL m9_down_step: got count=%0d tc=%b want 8 0", count_m, tc_m);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    step_clk();
    total++;
    if (count_w !== 4'd5 || tc_w !== 1'b0) begin
      bad++;
      $display("FAIL load_over_en: got count=%0d tc=%b want 5 0", count_w, tc_w);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
    step_clk();
    total++;
    if (count_w !== 4'd15 || ovf_w !== 1'b0 || count_m !== 4'd9) begin
      bad++;
      $display("FAIL reset_over_load: got count=%0d ovf=%b m9=%0d want 15 0 9", count_w, ovf_w, count_m);
    end
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
    step_clk();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step_clk();
    total++;
    if (count_w !== 4'd8) begin
      bad++;
      $display("FAIL ps_wait: got count=%0d want 8", count_w);
    end
    step_clk();
    total++;
    if (count_w !== 4'd7) begin
      bad++;
      $display("FAIL ps_tick: got count=%0d want 7", count_w);
    end
    step_clk();
    step_clk();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd8);
    step_clk();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step_clk();
    total++;
    if (count_w !== 4'd8) begin
      bad++;
      $display("FAIL ps_restart_wait: got count=%0d want 8", count_w);
    end
    step_clk();
    total++;
    if (count_w !== 4'd7) begin
      bad++;
      $display("FAIL ps_restart_tick: got count=%0d want 7", count_w);
    end
  endtask
`endif

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    test_reset();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`else
    test_down_wrap();
    test_up_wrap_hold();
    test_saturate();
    test_max_val();
    test_priority();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
